uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Shared UART transmit controller: round-robin arbitration among `N_REQ` byte sources onto one serial line. Frames are sequenced from the oversampling `baud_tick` supplied by the shared baud generator. The block owns the TX frame FSM (start, data, optional parity, stop) and the per-requester valid/ready handshake. It sits between the bus-side producers (CSR writes, debug/log sources) and the `tx` pin.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `TICKS_PER_BIT`, 16: `baud_tick` pulses per bit, ≥2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `baud_tick`  in  1  single-cycle oversampling strobe.
- `req_valid`  in  N_REQ  per-requester byte valid.
- `req_data`  in  N_REQ*DATA_BITS  flattened data; requester i uses bits [i*DATA_BITS +: DATA_BITS].
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.
- `grant_id`  out  $clog2(N_REQ)  index of the requester that owns the current or last frame.

## Operation
- FSM states: IDLE → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: if any `req_valid` is high, the arbiter picks a winner by round-robin, searching from `rr_ptr`.
  - `req_ready[winner]` is high combinationally in that same cycle; the handshake completes there.
  - `req_data` slice is latched into the shift register; `grant_id` ← winner; `rr_ptr` ← winner+1 mod N_REQ; go to LOAD.
- `req_ready` is all-zero in every state except IDLE. `req_valid` changes after acceptance are ignored.
- LOAD: `tx` stays high; wait for the next `baud_tick`, then go to START.
  - A tick in the acceptance cycle itself does not count.
- Each bit lasts exactly `TICKS_PER_BIT` ticks, counted by `tick_cnt` (width $clog2(TICKS_PER_BIT)).
  - The bit ends on the tick where `tick_cnt == TICKS_PER_BIT-1`; `tick_cnt` wraps to 0 there.
- START: `tx`=0.
- DATA: `tx` = shift_reg[0], LSB first; shift right at each bit end. `bit_cnt` (width $clog2(DATA_BITS+1)) counts to DATA_BITS.
- PARITY (only if PARITY_EN): `tx` = ^data XOR PARITY_ODD, computed on the latched byte.
- STOP: `tx`=1 for STOP_BITS×TICKS_PER_BIT ticks, then IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `rr_ptr`=0, state IDLE, all counters 0.
- `tx` is registered. It changes in the cycle after the qualifying `baud_tick`.
- Back-to-back frames:
  - STOP exits to IDLE on its last tick.
  - The earliest next accept is the following cycle.
  - The next start bit follows the first tick after LOAD.
- Frame length: 1 + DATA_BITS + PARITY_EN + STOP_BITS bits, plus 1–TICKS_PER_BIT ticks of LOAD latency.
- Reset asserted mid-frame: the frame is aborted and all state returns to reset values on the next clock edge; no partial stop bit.
- A single requester holding `req_valid` continuously is re-granted every frame. All others are served within N_REQ frames.

## Structure
- `uart_pkg` holds:
  - `tx_state_e` enum (IDLE, LOAD, START, DATA, PARITY, STOP);
  - shared defaults for DATA_BITS and TICKS_PER_BIT.
- Sub-module `uart_rr_arbiter` (`N_REQ`): a combinational one-hot grant from `req_valid` and `rr_ptr`, plus an encoded index.
  - `rr_ptr` is updated in the top only on accept.

## Test plan
- Tick every 4 cycles, TICKS_PER_BIT=4, one requester sends 0xA5 → `tx` shows 0, 1,0,1,0,0,1,0,1, 1; each bit exactly 16 cycles; `req_ready` high for one cycle.
- All four `req_valid` high continuously with distinct bytes 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0; serialized bytes match the grantee.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 → parity bit 1. PARITY_ODD=1 → parity bit 0. STOP_BITS=2 → stop high for 8 ticks.
- `baud_tick` in the acceptance cycle → LOAD still waits for the next tick; start-bit length stays exactly TICKS_PER_BIT ticks.
- `rst_n` low during DATA bit 3 → next cycle `tx`=1, `busy`=0, `grant_id`=0. After release, requester 0 wins first.
- Requester 2 drops `req_valid` and changes `req_data` after its accept → the frame carries the originally latched byte; `busy` stays high until STOP completes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_TICKS_PER_BIT = 16;
endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module uart_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_any
);
    localparam int IW = $clog2(N_REQ);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                grant_any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Shared UART transmitter: round-robin accept from N_REQ byte sources, then
// serialize start/data/[parity]/stop paced by the oversampling baud_tick.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       baud_tick,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS+1);

    tx_state_e              state, state_nxt;
    logic [DATA_BITS-1:0]   shift_reg, win_data;
    logic                   par_bit;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [IW-1:0]          rr_ptr, win_idx;
    logic [N_REQ-1:0]       win_grant;
    logic                   win_any, bit_end, last_data, last_stop;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign win_data  = req_data[win_idx*DATA_BITS +: DATA_BITS];
    assign bit_end   = baud_tick && (tick_cnt == TW'(TICKS_PER_BIT-1));
    assign last_data = (bit_cnt == BW'(DATA_BITS-1));
    assign last_stop = (bit_cnt == BW'(STOP_BITS-1));
    assign busy      = (state != IDLE);
    // Ready is held off during reset so no handshake completes into a flushed block.
    assign req_ready = (state == IDLE && rst_n) ? win_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any)               state_nxt = LOAD;
            LOAD:    if (baud_tick)             state_nxt = START;
            START:   if (bit_end)               state_nxt = DATA;
            DATA:    if (bit_end && last_data)  state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end)               state_nxt = STOP;
            STOP:    if (bit_end && last_stop)  state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state inside {START, DATA, PARITY, STOP} && baud_tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            case (state)
                IDLE: if (win_any) begin
                    shift_reg <= win_data;
                    par_bit   <= (^win_data) ^ (PARITY_ODD != 0);
                    grant_id  <= win_idx;
                    rr_ptr    <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                end
                LOAD:  if (baud_tick) tx <= 1'b0;
                START: if (bit_end)   tx <= shift_reg[0];
                DATA: if (bit_end) begin
                    shift_reg <= shift_reg >> 1;
                    if (last_data) begin
                        bit_cnt <= '0;
                        tx      <= (PARITY_EN != 0) ? par_bit : 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= shift_reg[1];
                    end
                end
                PARITY: if (bit_end) tx <= 1'b1;
                STOP:   if (bit_end) bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench: three transmitter variants share one set of requesters.
module tb_uart_tx_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        baud_tick = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  rdy0, rdy1, rdy2;
    logic        tx0, tx1, tx2, busy0, busy1, busy2;
    logic [1:0]  gid0, gid1, gid2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tph = 0;

    // dut0: plain 8N1; dut1: even parity, 2 stop; dut2: odd parity, 1 stop
    uart_tx_arb #(.N_REQ(4), .DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy0), .tx(tx0), .busy(busy0), .grant_id(gid0));
    uart_tx_arb #(.N_REQ(4), .DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy1), .tx(tx1), .busy(busy1), .grant_id(gid1));
    uart_tx_arb #(.N_REQ(4), .DATA_BITS(8), .TICKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy2), .tx(tx2), .busy(busy2), .grant_id(gid2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        baud_tick = (tph == 3);
        tph = (tph + 1) % 4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Run-length monitor on dut0 tx, plus ready/grant monitor on dut0
    bit   mon_runs = 0, mon_grant = 0;
    int   runs[$];
    int   grants[$];
    int   run_cur = 0, ready_cnt = 0;
    logic run_last = 1'b1;

    always @(negedge clk) begin
        if (mon_runs) begin
            if (tx0 === run_last) run_cur++;
            else begin
                runs.push_back(run_cur);
                run_cur  = 1;
                run_last = tx0;
            end
        end
        if (mon_grant && |rdy0) begin
            ready_cnt++;
            chk("ready_onehot", 32'($onehot(rdy0)), 1);
            for (int i = 0; i < 4; i++) if (rdy0[i]) grants.push_back(i);
        end
    end

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx0 : (w == 1) ? tx1 : tx2;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
    endfunction
    function automatic logic [15:0] fr8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    // Samples each bit mid-period; flen = cycles from tx fall to busy drop
    task automatic rx_frame(input int w, input int nbits, output logic [15:0] bits, output int flen);
        int n;
        int t0;
        bits = '0;
        flen = 0;
        n    = 0;
        @(negedge clk);
        while (tx_of(w) !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin chk("rx_timeout", 1, 0); return; end
        t0 = cyc;
        repeat (8) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            bits[k] = tx_of(w);
            if (k < nbits-1) repeat (16) @(negedge clk);
        end
        n = 0;
        while (busy_of(w) !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        flen = cyc - t0;
    endtask

    task automatic send(input int i, input logic [7:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_data[i*8 +: 8] = d;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (rdy0[i] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] b0, b1, b2;
        int f0, f1, f2, n;

        rst_n = 1'b0;
        req_valid = 4'hF;
        req_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", rdy0, 0);
        chk("rst_gid", gid0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '0;

        // 0xA5 on requester 0: bit pattern, bit durations, single-cycle ready
        runs.delete(); run_cur = 0; run_last = 1'b1; mon_runs = 1;
        ready_cnt = 0; mon_grant = 1;
        send(0, 8'hA5);
        rx_frame(0, 10, b0, f0);
        mon_runs = 0;
        chk("a5_bits", b0, fr8n1(8'hA5));
        chk("a5_len", f0, 160);
        chk("a5_ready_cycles", ready_cnt, 1);
        chk("a5_gid", gid0, 0);
        chk("a5_nruns", runs.size() >= 8, 1);
        if (runs.size() >= 8) begin
            chk("a5_run_start", runs[1], 16);
            chk("a5_run_b0", runs[2], 16);
            chk("a5_run_b1", runs[3], 16);
            chk("a5_run_b2", runs[4], 16);
            chk("a5_run_b34", runs[5], 32);
            chk("a5_run_b5", runs[6], 16);
            chk("a5_run_b6", runs[7], 16);
        end

        // Parity and stop-bit variants, all fed the same 0x07 accept
        do_reset();
        send(1, 8'h07);
        fork
            rx_frame(0, 10, b0, f0);
            rx_frame(1, 12, b1, f1);
            rx_frame(2, 11, b2, f2);
        join
        chk("p_none_bits", b0, fr8n1(8'h07));
        chk("p_even_bits", b1, {4'b0, 2'b11, 1'b1, 8'h07, 1'b0});
        chk("p_odd_bits", b2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0});
        chk("p_even_bit", b1[9], 1);
        chk("p_odd_bit", b2[9], 0);
        chk("p_even_2stop_len", f1, 192);
        chk("p_odd_len", f2, 176);

        // Tick coincident with acceptance must not shorten LOAD
        do_reset();
        runs.delete(); run_cur = 0; run_last = 1'b1; mon_runs = 1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!baud_tick && n < 10);
        req_data[31:24] = 8'hC3;
        req_valid[3] = 1'b1;
        @(negedge clk);
        chk("tick_acc_ready", rdy0, 4'b1000);
        chk("tick_acc_tick", baud_tick, 1);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        n = 0;
        @(negedge clk);
        while (tx0 === 1'b1 && n < 50) begin n++; @(negedge clk); end
        chk("tick_acc_load_wait", n, 4);
        chk("tick_acc_gid", gid0, 3);
        n = 0;
        while (busy0 !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        mon_runs = 0;
        chk("tick_acc_nruns", runs.size() >= 4, 1);
        if (runs.size() >= 4) begin
            chk("tick_acc_start", runs[1], 16);
            chk("tick_acc_ones", runs[2], 32);
            chk("tick_acc_zeros", runs[3], 64);
        end

        // All four requesters held: round-robin service order
        do_reset();
        grants.delete();
        req_data = 32'h44332211;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            rx_frame(0, 10, b0, f0);
            chk("rr_bits", b0, fr8n1(8'((k % 4 + 1) * 8'h11)));
            chk("rr_gid", gid0, k % 4);
            chk("rr_len", f0, 160);
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++)
            chk("rr_order", (k < grants.size()) ? grants[k] : 99, k % 4);

        // Reset in the middle of data bit 3 aborts the frame cleanly
        do_reset();
        send(2, 8'hA5);
        n = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (8 + 16*4) @(negedge clk);
        chk("mid_busy_pre", busy0, 1);
        chk("mid_gid_pre", gid0, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tx", tx0, 1);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_gid", gid0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mid_post_ready", rdy0, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("mid_post_gid", gid0, 0);

        // Requester 2 retracts and changes data after accept
        do_reset();
        send(2, 8'h3C);
        req_data[23:16] = 8'hFF;
        rx_frame(0, 10, b0, f0);
        chk("latch_bits", b0, fr8n1(8'h3C));
        chk("latch_len", f0, 160);
        chk("latch_gid", gid0, 2);
        repeat (40) @(negedge clk);
        chk("latch_idle", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
